// File: rtl/arbitro_mux_pkg.sv
// Shared types and constants for the two-requester round-robin arbiter.
package pacote_arbitro;

  localparam int unsigned LARGURA_DADO = 8;

  typedef enum logic [1:0] {
    OCIOSO,
    SERVE1,
    SERVE2
  } estado_t;

endpackage

// File: rtl/arbitro_mux_if.sv
// Requester, MUX-select and output-stage signals of the arbiter.
interface arbitro_mux_if;
  import pacote_arbitro::*;

  logic                    Req1;
  logic                    Req2;
  logic [LARGURA_DADO-1:0] Entrada1;
  logic [LARGURA_DADO-1:0] Entrada2;
  logic                    Concedido1;
  logic                    Concedido2;
  logic                    SinalControle;
  logic [LARGURA_DADO-1:0] Saida;
  logic                    SaidaValida;
  logic                    SaidaPronta;

  // Environment side: requesters and downstream consumer.
  modport master (
    output Req1, Req2, Entrada1, Entrada2, SaidaPronta,
    input  Concedido1, Concedido2, SinalControle, Saida, SaidaValida
  );

  // Arbiter side.
  modport slave (
    input  Req1, Req2, Entrada1, Entrada2, SaidaPronta,
    output Concedido1, Concedido2, SinalControle, Saida, SaidaValida
  );

endinterface

// File: rtl/arbitro_mux_mux.sv
// Existing shared 8-bit 2:1 datapath MUX; 0 selects Entrada1, 1 selects Entrada2.
module MUX
  import pacote_arbitro::*;
(
  input  logic [LARGURA_DADO-1:0] Entrada1,
  input  logic [LARGURA_DADO-1:0] Entrada2,
  input  logic                    SinalControle,
  output logic [LARGURA_DADO-1:0] Saida
);

  assign Saida = SinalControle ? Entrada2 : Entrada1;

endmodule

// File: rtl/arbitro_mux.sv
// Round-robin arbiter with burst limit driving the shared MUX, plus a one-entry output stage.
module arbitro_mux
  import pacote_arbitro::*;
#(
  parameter int unsigned MAX_RAJADA = 4
) (
  input  logic          Clock,
  input  logic          Reset_n,
  arbitro_mux_if.slave  bus
);

  localparam int unsigned LarguraCont = $clog2(MAX_RAJADA + 1);
  localparam logic [LarguraCont-1:0] LimiteCont = LarguraCont'(MAX_RAJADA);

  estado_t                 estado_q, estado_d;
  logic [LarguraCont-1:0]  contador_q, contador_d, contador_inc;
  logic                    ultimo_q, ultimo_d;  // 1 means requester 2 was served last
  logic                    sel_q, sel_d;
  logic [LARGURA_DADO-1:0] saida_q, saida_d;
  logic                    valida_q, valida_d;
  logic [LARGURA_DADO-1:0] mux_saida;
  logic                    pode_capturar, conc1, conc2, captura, fim_rajada;

  MUX u_mux (
    .Entrada1      (bus.Entrada1),
    .Entrada2      (bus.Entrada2),
    .SinalControle (sel_q),
    .Saida         (mux_saida)
  );

  assign pode_capturar = !valida_q || bus.SaidaPronta;
  assign conc1         = (estado_q == SERVE1) && bus.Req1 && pode_capturar;
  assign conc2         = (estado_q == SERVE2) && bus.Req2 && pode_capturar;
  assign captura       = conc1 || conc2;
  assign contador_inc  = contador_q + LarguraCont'(1);
  assign fim_rajada    = (contador_inc == LimiteCont);

  always_comb begin
    estado_d   = estado_q;
    contador_d = contador_q;
    ultimo_d   = ultimo_q;
    saida_d    = saida_q;
    valida_d   = valida_q;

    if (captura) begin
      saida_d  = mux_saida;
      valida_d = 1'b1;
    end else if (valida_q && bus.SaidaPronta) begin
      valida_d = 1'b0;
    end

    unique case (estado_q)
      OCIOSO: begin
        contador_d = '0;
        if (bus.Req1 && bus.Req2) begin
          estado_d = ultimo_q ? SERVE1 : SERVE2;
        end else if (bus.Req1) begin
          estado_d = SERVE1;
        end else if (bus.Req2) begin
          estado_d = SERVE2;
        end
      end
      SERVE1: begin
        if (conc1) begin
          ultimo_d   = 1'b0;
          contador_d = fim_rajada ? '0 : contador_inc;
          if (fim_rajada && bus.Req2) estado_d = SERVE2;
        end else if (!bus.Req1) begin
          contador_d = '0;
          estado_d   = bus.Req2 ? SERVE2 : OCIOSO;
        end
      end
      SERVE2: begin
        if (conc2) begin
          ultimo_d   = 1'b1;
          contador_d = fim_rajada ? '0 : contador_inc;
          if (fim_rajada && bus.Req1) estado_d = SERVE1;
        end else if (!bus.Req2) begin
          contador_d = '0;
          estado_d   = bus.Req1 ? SERVE1 : OCIOSO;
        end
      end
      default: begin
        estado_d   = OCIOSO;
        contador_d = '0;
      end
    endcase

    // Select is registered alongside the state so Req never reaches the MUX combinationally.
    sel_d = (estado_d == SERVE2);
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      estado_q   <= OCIOSO;
      contador_q <= '0;
      ultimo_q   <= 1'b1;
      sel_q      <= 1'b0;
      saida_q    <= '0;
      valida_q   <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      contador_q <= contador_d;
      ultimo_q   <= ultimo_d;
      sel_q      <= sel_d;
      saida_q    <= saida_d;
      valida_q   <= valida_d;
    end
  end

  assign bus.Concedido1    = conc1;
  assign bus.Concedido2    = conc2;
  assign bus.SinalControle = sel_q;
  assign bus.Saida         = saida_q;
  assign bus.SaidaValida   = valida_q;

endmodule

// File: tb/tb_arbitro_mux.sv
// Directed and randomized checks of arbitro_mux against a requester-level reference model.
module tb_arbitro_mux;

  localparam int MaxR = 4;

  logic Clock = 1'b0;
  logic Reset_n = 1'b0;

  arbitro_mux_if bus ();

  arbitro_mux #(.MAX_RAJADA(MaxR)) dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: who owns the datapath, how many words in this burst, who was last.
  int       owner;
  int       burst;
  int       last;
  bit [7:0] m_out;
  bit       m_val;
  bit       obs_g1, obs_g2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner = 0;
    burst = 0;
    last  = 2;
    m_out = 8'h00;
    m_val = 1'b0;
  endtask

  // Compare at the falling edge, then advance the model across the rising edge.
  task automatic tick();
    bit       req[1:2];
    bit [7:0] ent[1:2];
    bit       g;
    int       other;
    @(negedge Clock);
    req[1] = bus.Req1;
    req[2] = bus.Req2;
    ent[1] = bus.Entrada1;
    ent[2] = bus.Entrada2;
    g = (owner != 0) && req[owner] && (!m_val || bus.SaidaPronta);
    chk("concedido1", bus.Concedido1, g && owner == 1);
    chk("concedido2", bus.Concedido2, g && owner == 2);
    chk("sinal_controle", bus.SinalControle, owner == 2);
    chk("saida", bus.Saida, m_out);
    chk("saida_valida", bus.SaidaValida, m_val);
    obs_g1 = bus.Concedido1;
    obs_g2 = bus.Concedido2;
    other = 3 - owner;
    if (g) begin
      m_out = ent[owner];
      m_val = 1'b1;
      last  = owner;
      burst = burst + 1;
      if (burst == MaxR) begin
        burst = 0;
        if (req[other]) owner = other;
      end
    end else begin
      if (m_val && bus.SaidaPronta) m_val = 1'b0;
      if (owner == 0) begin
        burst = 0;
        if (req[1] && req[2]) owner = 3 - last;
        else if (req[1]) owner = 1;
        else if (req[2]) owner = 2;
      end else if (!req[owner]) begin
        burst = 0;
        owner = req[other] ? other : 0;
      end
    end
    @(posedge Clock);
    #1;
  endtask

  // Called at posedge+1; asserts reset between edges and releases before the next falling edge.
  task automatic do_reset(input string tag);
    Reset_n = 1'b0;
    #2;
    chk({tag, "_saida"}, bus.Saida, 8'h00);
    chk({tag, "_valida"}, bus.SaidaValida, 1'b0);
    chk({tag, "_sel"}, bus.SinalControle, 1'b0);
    chk({tag, "_conc"}, {bus.Concedido1, bus.Concedido2}, 2'b00);
    model_reset();
    #1;
    Reset_n = 1'b1;
  endtask

  task automatic set_in(input bit r1, input bit r2, input bit [7:0] e1, input bit [7:0] e2,
                        input bit pr);
    bus.Req1        = r1;
    bus.Req2        = r2;
    bus.Entrada1    = e1;
    bus.Entrada2    = e2;
    bus.SaidaPronta = pr;
  endtask

  initial begin
    int cnt;
    int exp_id;
    int obs_id;
    model_reset();
    set_in(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_saida", bus.Saida, 8'h00);
    chk("rst_valida", bus.SaidaValida, 1'b0);
    chk("rst_sel", bus.SinalControle, 1'b0);
    #3;
    Reset_n = 1'b1;

    // Single requester latency.
    set_in(1'b1, 1'b0, 8'hAA, 8'h00, 1'b1);
    tick();
    chk("lat_sel", bus.SinalControle, 1'b0);
    chk("lat_conc1", bus.Concedido1, 1'b1);
    tick();
    chk("lat_saida", bus.Saida, 8'hAA);
    chk("lat_valida", bus.SaidaValida, 1'b1);

    // Both requesting from reset: bursts of MaxR alternating with no gap.
    do_reset("rst_b");
    set_in(1'b1, 1'b1, 8'hAA, 8'hFD, 1'b1);
    for (int t = 1; t <= 20; t++) begin
      tick();
      exp_id = (t == 1) ? 0 : ((((t - 2) / MaxR) % 2 == 0) ? 1 : 2);
      obs_id = obs_g1 ? 1 : (obs_g2 ? 2 : 0);
      chk("burst_id", obs_id, exp_id);
    end

    // Only requester 2 for ten words.
    do_reset("rst_c");
    set_in(1'b0, 1'b1, 8'h00, 8'h10, 1'b1);
    cnt = 0;
    for (int t = 0; t < 11; t++) begin
      tick();
      if (obs_g2) begin
        cnt++;
        bus.Entrada2 = bus.Entrada2 + 8'h01;
      end
    end
    chk("solo2_count", cnt, 10);
    chk("solo2_sel", bus.SinalControle, 1'b1);

    // Backpressure after the first capture.
    do_reset("rst_d");
    set_in(1'b1, 1'b0, 8'hAA, 8'h00, 1'b1);
    tick();
    tick();
    bus.SaidaPronta = 1'b0;
    cnt = 0;
    repeat (5) begin
      tick();
      cnt += int'(obs_g1);
    end
    chk("bp_no_grant", cnt, 0);
    chk("bp_saida", bus.Saida, 8'hAA);
    bus.SaidaPronta = 1'b1;
    tick();
    chk("bp_release_grant", obs_g1, 1'b1);

    // Requester 1 drops mid-burst while requester 2 waits.
    do_reset("rst_e");
    set_in(1'b1, 1'b1, 8'h11, 8'h22, 1'b1);
    repeat (3) tick();
    bus.Req1 = 1'b0;
    tick();
    chk("drop_gap", {obs_g1, obs_g2}, 2'b00);
    tick();
    chk("drop_then2", obs_g2, 1'b1);
    chk("drop_sel", bus.SinalControle, 1'b1);

    // Reset mid-burst with a pending word, then the tie goes to requester 1.
    chk("mid_valid_before", bus.SaidaValida, 1'b1);
    do_reset("rst_mid");
    set_in(1'b1, 1'b1, 8'h33, 8'h44, 1'b1);
    tick();
    tick();
    chk("mid_tie_r1", obs_g1, 1'b1);

    // Randomized traffic obeying the hold-until-granted protocol.
    do_reset("rst_r");
    set_in(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    for (int t = 0; t < 3000; t++) begin
      if (!bus.Req1 || obs_g1) begin
        bus.Req1     = ($urandom_range(0, 3) != 0);
        bus.Entrada1 = 8'($urandom);
      end
      if (!bus.Req2 || obs_g2) begin
        bus.Req2     = ($urandom_range(0, 3) != 0);
        bus.Entrada2 = 8'($urandom);
      end
      bus.SaidaPronta = ($urandom_range(0, 3) != 0);
      obs_g1 = 1'b0;
      obs_g2 = 1'b0;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
